// File: rtl/im_data_tx_if.sv
// Pixel-link bundle: 24-bit word handshake in, 6-bit chunk stream out.
interface im_data_tx_if;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [5:0]  im_data;
    logic        im_data_val;

    // Word source and link sink side (testbench / upstream logic)
    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  im_data,
        input  im_data_val
    );

    // Transmitter side
    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output im_data,
        output im_data_val
    );
endinterface

// File: rtl/im_data_tx.sv
// Imager link transmitter: serialises 24-bit words into MSB-first 6-bit
// chunks, framed into rows and frames separated by programmable idle gaps.
module im_data_tx #(
    parameter int WORDS_PER_ROW  = 8,
    parameter int ROWS_PER_FRAME = 4,
    parameter int LINE_GAP       = 3,
    parameter int FRAME_GAP      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    im_data_tx_if.slave bus,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LGAP, FGAP} state_t;

    // Terminal counts; all counters compare against PARAM-1 so none wraps.
    localparam logic [11:0] LAST_WORD = 12'(WORDS_PER_ROW - 1);
    localparam logic [11:0] LAST_ROW  = 12'(ROWS_PER_FRAME - 1);
    localparam logic [7:0]  LAST_LGAP = 8'(LINE_GAP - 1);
    localparam logic [7:0]  LAST_FGAP = 8'(FRAME_GAP - 1);

    state_t      state;
    logic [1:0]  phase;
    logic [11:0] word_cnt;
    logic [11:0] row_cnt;
    logic [7:0]  gap_cnt;
    logic [23:0] shift_reg;
    logic        last_word;
    logic        last_row;
    logic        xfer;

    // word_cnt is the index of the word being shifted or fetched in this row
    assign last_word = (word_cnt == LAST_WORD);
    assign last_row  = (row_cnt == LAST_ROW);
    assign xfer      = bus.s_valid & bus.s_ready;

    // Ready is decoded from state/phase only; abort and reset block acceptance
    always_comb begin
        bus.s_ready = 1'b0;
        if (rst_n && !abort) begin
            if (state == FETCH)
                bus.s_ready = 1'b1;
            else if (state == SHIFT && phase == 2'd3 && !last_word)
                bus.s_ready = 1'b1;
        end
    end

    // Frame sequencer with registered link outputs and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            phase           <= 2'd0;
            word_cnt        <= 12'd0;
            row_cnt         <= 12'd0;
            gap_cnt         <= 8'd0;
            shift_reg       <= 24'd0;
            bus.im_data     <= 6'd0;
            bus.im_data_val <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                // Abort in IDLE also swallows a coincident start
                if (state != IDLE) begin
                    state           <= IDLE;
                    bus.im_data     <= 6'd0;
                    bus.im_data_val <= 1'b0;
                    busy            <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy     <= 1'b1;
                            underrun <= 1'b0;
                            word_cnt <= 12'd0;
                            row_cnt  <= 12'd0;
                            gap_cnt  <= 8'd0;
                            phase    <= 2'd0;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (xfer) begin
                            bus.im_data     <= bus.s_data[23:18];
                            bus.im_data_val <= 1'b1;
                            shift_reg       <= {bus.s_data[17:0], 6'd0};
                            phase           <= 2'd0;
                            state           <= SHIFT;
                        end else if (word_cnt != 12'd0) begin
                            // Waiting on a mid-row word means the source fell behind
                            underrun <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (phase != 2'd3) begin
                            bus.im_data <= shift_reg[23:18];
                            shift_reg   <= {shift_reg[17:0], 6'd0};
                            phase       <= phase + 2'd1;
                        end else if (!last_word) begin
                            word_cnt <= word_cnt + 12'd1;
                            if (xfer) begin
                                // Reload without a bubble: one word per four cycles
                                bus.im_data <= bus.s_data[23:18];
                                shift_reg   <= {bus.s_data[17:0], 6'd0};
                                phase       <= 2'd0;
                            end else begin
                                bus.im_data     <= 6'd0;
                                bus.im_data_val <= 1'b0;
                                state           <= FETCH;
                            end
                        end else begin
                            word_cnt        <= 12'd0;
                            gap_cnt         <= 8'd0;
                            bus.im_data     <= 6'd0;
                            bus.im_data_val <= 1'b0;
                            if (!last_row) begin
                                row_cnt <= row_cnt + 12'd1;
                                state   <= (LINE_GAP == 0) ? FETCH : LGAP;
                            end else if (FRAME_GAP == 0) begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= FGAP;
                            end
                        end
                    end
                    LGAP: begin
                        if (gap_cnt == LAST_LGAP)
                            state <= FETCH;
                        else
                            gap_cnt <= gap_cnt + 8'd1;
                    end
                    FGAP: begin
                        if (gap_cnt == LAST_FGAP) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_data_tx.sv
// Bench for im_data_tx: randomized frames against a frame-level model,
// plus directed single-word, abort, restart and reset scenarios.
module tb_im_data_tx;
    localparam int W  = 4;
    localparam int R  = 2;
    localparam int LG = 3;
    localparam int FG = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort;
    logic busy, frame_done, underrun;
    logic start1, abort1;
    logic busy1, frame_done1, underrun1;

    int vectors = 0;
    int miscompares = 0;

    im_data_tx_if bus ();
    im_data_tx_if bus1 ();

    im_data_tx #(.WORDS_PER_ROW(W), .ROWS_PER_FRAME(R), .LINE_GAP(LG), .FRAME_GAP(FG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus.slave),
        .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    im_data_tx #(.WORDS_PER_ROW(1), .ROWS_PER_FRAME(1), .LINE_GAP(0), .FRAME_GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .bus(bus1.slave),
        .busy(busy1), .frame_done(frame_done1), .underrun(underrun1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame on dut. Model: chunks are the words MSB first; a mid-row word
    // held back d>3 cycles after the previous transfer costs d-3 idle cycles,
    // and d>=5 leaves the block waiting in a mid-row fetch (underrun).
    task automatic frame_a(input int dmax, input int force_idx, input int force_d,
                           input int abort_at, input int restart_at);
        logic [23:0] words[$];
        logic [5:0]  expq[$];
        int          dly[$];
        logic [23:0] w;
        int n, exp_cycles, k, since, nval, d;
        bit exp_und, done, aborted, xfer;
        n = W * R;
        exp_cycles = R * (1 + 4 * W) + (R - 1) * LG + FG;
        exp_und = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = 24'($urandom);
            words.push_back(w);
            if (i == 0) d = 0;
            else if (i % W == 0) d = int'($urandom_range(0, 3));
            else d = int'($urandom_range(0, dmax));
            if (i == force_idx) d = force_d;
            if (i % W != 0) begin
                if (d > 3) exp_cycles += d - 3;
                if (d >= 5) exp_und = 1'b1;
            end
            dly.push_back(d);
            for (int cc = 0; cc < 4; cc++) expq.push_back(w[23 - 6 * cc -: 6]);
        end
        k = 0; since = 0; nval = 0; done = 1'b0; aborted = 1'b0;
        start = 1'b1;
        for (int c = 0; c < exp_cycles + 40 && !done; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (bus.im_data_val) begin
                if (nval == abort_at) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end
                if (expq.size() > 0) chk("chunk", 32'(bus.im_data), 32'(expq.pop_front()));
                else chk("extra chunk", 32'(1), 32'(0));
                nval++;
            end else begin
                chk("idle data", 32'(bus.im_data), 32'(0));
            end
            if (frame_done) begin
                done = 1'b1;
                chk("frame length", c, exp_cycles);
                chk("busy at done", 32'(busy), 32'(0));
            end else begin
                chk("busy in frame", 32'(busy), 32'(1));
            end
            bus.s_valid = (k < n) ? (since >= dly[k]) : 1'b0;
            bus.s_data  = (k < n) ? words[k] : 24'h0;
            #1;
            xfer = bus.s_valid & bus.s_ready;
            if (aborted) begin
                chk("s_ready in abort", 32'(bus.s_ready), 32'(0));
                break;
            end
            if (xfer) begin k++; since = 0; end
            else since++;
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            chk("abort val", 32'(bus.im_data_val), 32'(0));
            chk("abort busy", 32'(busy), 32'(0));
            chk("abort s_ready", 32'(bus.s_ready), 32'(0));
            bus.s_valid = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                chk("no done after abort", 32'(frame_done), 32'(0));
                chk("quiet after abort", 32'(bus.im_data_val), 32'(0));
            end
        end else begin
            if (!done) chk("frame_done seen", 32'(0), 32'(1));
            chk("chunks left", expq.size(), 0);
            chk("underrun", 32'(underrun), 32'(exp_und));
            bus.s_valid = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("single done", 32'(frame_done), 32'(0));
                chk("quiet after frame", 32'(bus.im_data_val), 32'(0));
                chk("underrun hold", 32'(underrun), 32'(exp_und));
            end
        end
    endtask

    initial begin
        logic [5:0] exp1[4];
        bit seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 24'h0;
        bus1.s_valid = 1'b0; bus1.s_data = 24'h0;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst val", 32'(bus.im_data_val), 32'(0));
        chk("rst data", 32'(bus.im_data), 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst done", 32'(frame_done), 32'(0));
        chk("rst underrun", 32'(underrun), 32'(0));
        chk("rst ready", 32'(bus.s_ready), 32'(0));
        chk("rst busy1", 32'(busy1), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle ready", 32'(bus.s_ready), 32'(0));

        // Single word on the 1x1 instance with no frame gap
        exp1[0] = 6'h3F; exp1[1] = 6'h00; exp1[2] = 6'h3F; exp1[3] = 6'h03;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        bus1.s_valid = 1'b1; bus1.s_data = 24'hFC0FC3;
        #1 chk("single ready", 32'(bus1.s_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.s_valid = 1'b0;
            chk("single val", 32'(bus1.im_data_val), 32'(1));
            chk("single chunk", 32'(bus1.im_data), 32'(exp1[i]));
        end
        @(negedge clk);
        chk("single done", 32'(frame_done1), 32'(1));
        chk("single busy", 32'(busy1), 32'(0));
        chk("single underrun", 32'(underrun1), 32'(0));
        chk("single val off", 32'(bus1.im_data_val), 32'(0));
        @(negedge clk);
        chk("single done pulse", 32'(frame_done1), 32'(0));

        // Ideal back-to-back frame, then a forced mid-row underrun
        frame_a(3, -1, 0, -1, -1);
        frame_a(3, 2, 8, -1, -1);
        // Abort mid-word (start clears the sticky underrun), then at phase 3
        frame_a(3, -1, 0, 9, -1);
        chk("underrun cleared", 32'(underrun), 32'(0));
        frame_a(0, -1, 0, 11, -1);
        // Random frames, and a start pulse while busy
        for (int f = 0; f < 4; f++) frame_a(7, -1, 0, -1, -1);
        frame_a(5, -1, 0, -1, 6);

        // start together with abort while idle: stays idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'(0));
        chk("start+abort ready", 32'(bus.s_ready), 32'(0));

        // Reset during SHIFT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 24'h123456;
        @(negedge clk);
        chk("pre-reset val", 32'(bus.im_data_val), 32'(1));
        chk("pre-reset chunk", 32'(bus.im_data), 32'(6'h04));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid rst val", 32'(bus.im_data_val), 32'(0));
        chk("mid rst data", 32'(bus.im_data), 32'(0));
        chk("mid rst busy", 32'(busy), 32'(0));
        chk("mid rst done", 32'(frame_done), 32'(0));
        chk("mid rst underrun", 32'(underrun), 32'(0));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 if (bus.s_ready) seen = 1'b1;
            @(negedge clk);
            if (bus.im_data_val) seen = 1'b1;
        end
        chk("no accept after reset", 32'(seen), 32'(0));
        bus.s_valid = 1'b0;
        frame_a(3, -1, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
